// File: rtl/bram_fifo_if.sv
// Ready/valid bundle for bram_fifo. The FIFO binds the slave modport.
// The producer/consumer side binds the master modport.
interface bram_fifo_if #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 9
);
    logic                  in_valid;
    logic [WIDTH-1:0]      in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic                  out_ready;
    logic [DEPTH_LOG2:0]   count;
    logic                  almost_full;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count, almost_full
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count, almost_full
    );
endinterface

// File: rtl/bram_fifo.sv
// Single-clock FIFO on an inferred simple-dual-port RAM with a show-ahead output.
// A one-entry skid stage (the RAM read register) sits between the RAM and the output register.
module bram_fifo #(
    parameter int WIDTH       = 8,
    parameter int DEPTH_LOG2  = 9,
    parameter int ALMOST_FULL = 508
) (
    input  logic          CLK,
    input  logic          reset,
    bram_fifo_if.slave    bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr, rptr;
    logic [CW-1:0]         count_q, count_d, mem_entries;
    logic                  out_valid_q, q_valid, in_ready_q, almost_full_q;
    logic [WIDTH-1:0]      ram_q, out_data_q;
    logic                  push, pop, out_load, rd_en, bypass, mem_wr;

    // The read register holds the next head, so a pop refills the output without a bubble.
    // A push that meets a pop of the last word goes straight into that register.
    always_comb begin
        push        = bus.in_valid && in_ready_q;
        pop         = out_valid_q && bus.out_ready;
        mem_entries = count_q - CW'(out_valid_q) - CW'(q_valid);
        out_load    = q_valid && (!out_valid_q || pop);
        rd_en       = (mem_entries != '0) && (!q_valid || out_load);
        bypass      = push && pop && !q_valid && (mem_entries == '0);
        mem_wr      = push && !bypass;
        count_d     = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            count_q       <= '0;
            out_valid_q   <= 1'b0;
            q_valid       <= 1'b0;
            wptr          <= '0;
            rptr          <= '0;
            in_ready_q    <= 1'b1;
            almost_full_q <= (ALMOST_FULL == 0);
        end else begin
            count_q       <= count_d;
            in_ready_q    <= (count_d < CW'(DEPTH));
            almost_full_q <= (count_d >= CW'(ALMOST_FULL));
            if (mem_wr) begin
                wptr <= wptr + DEPTH_LOG2'(1);
            end
            if (rd_en) begin
                rptr <= rptr + DEPTH_LOG2'(1);
            end
            if (rd_en || bypass) begin
                q_valid <= 1'b1;
            end else if (out_load) begin
                q_valid <= 1'b0;
            end
            if (out_load) begin
                out_valid_q <= 1'b1;
            end else if (pop) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // The datapath carries no reset, so stale words are masked by the valid flags alone.
    always_ff @(posedge CLK) begin
        if (mem_wr) begin
            mem[wptr] <= bus.in_data;
        end
        if (rd_en) begin
            ram_q <= mem[rptr];
        end else if (bypass) begin
            ram_q <= bus.in_data;
        end
        if (out_load) begin
            out_data_q <= ram_q;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.count       = count_q;
    assign bus.almost_full = almost_full_q;
endmodule

// File: doc/bram_fifo.md
Name: bram_fifo

Overview:
- Parametrised single-clock FIFO built on an inferred simple-dual-port block RAM: one write port, one synchronous read port, read latency 1.
- Replaces fixed-width, fixed-depth RAMB16 primitive wrappers where pipeline stages need elastic buffering (line buffers, rate-matching between generator stages).
- Ready/valid on both sides, show-ahead output register, occupancy count and almost-full flag for upstream back-pressure planning.

Parameters:
- WIDTH, 8, data width in bits (1..72).
- DEPTH_LOG2, 9, log2 of capacity; capacity DEPTH = 2^DEPTH_LOG2 entries total, output register included.
- ALMOST_FULL, 508, almost_full asserts when count >= ALMOST_FULL; legal range 1..DEPTH.

Ports:
- CLK  input  1  clock, all state on rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  upstream has data.
- in_data  input  WIDTH  write data.
- in_ready  output  1  FIFO accepts a word this cycle.
- out_valid  output  1  out_data holds the head entry.
- out_data  output  WIDTH  head entry, registered.
- out_ready  input  1  downstream consumes the head this cycle.
- count  output  DEPTH_LOG2+1  entries held, output register included.
- almost_full  output  1  count >= ALMOST_FULL.

Behaviour:
- Interface: one clock (CLK); reset is synchronous and active-high.
- Push: in_valid && in_ready at an edge. Pop: out_valid && out_ready at an edge.
- Reset values: count=0, out_valid=0, in_ready=1, almost_full=(ALMOST_FULL==0 ? 1 : 0), i.e. 0 for legal parameters. out_data is don't-care until the first out_valid.
- RAM array is never reset. Contents after reset are undefined and must never be observable on out_data while out_valid=1.
- Reset asserted mid-operation: all stored entries are discarded. Next cycle the outputs show reset values, regardless of in_valid/out_ready.
- in_ready = (count < DEPTH). It is a registered function of count only, with no combinational path from out_ready or in_valid.
  - A pop in the same cycle as full does not allow a push in that cycle.
- count update per edge: +1 on push only, -1 on pop only, unchanged on both or neither. It never exceeds DEPTH and never goes below 0.
- almost_full is registered, consistent with count after the same edge.
- Storage: write pointer wptr and read pointer rptr are DEPTH_LOG2 bits and wrap modulo DEPTH. The RAM holds count minus out_valid entries.
- Output stage is show-ahead:
  - The RAM read is issued when the output register is empty, or is being popped, and the RAM holds at least one entry.
  - Read data lands in out_data one edge after issue, with out_valid=1.
- Latency: a word pushed at edge t into an empty FIFO has out_valid=1 from edge t+2. It is never bypassed combinationally.
- Throughput: with the FIFO holding at least 2 entries, continuous out_ready gives one pop per cycle, with no bubbles.
  - The read for the next entry is issued in the same cycle as the current pop.
  - An implementation may add one skid register to achieve this, provided capacity and count semantics are unchanged.
- Simultaneous push and pop when empty: impossible, because out_valid=0.
- Simultaneous push and pop with count=1: count stays 1, and the new word becomes head 2 edges later. out_valid may drop for at most 1 cycle in this case only.
- Read-during-write to the same RAM address cannot be required by the pointer rules; any RAM write mode is acceptable.
- Ordering is strict FIFO. There is no loss or duplication under any in_valid/out_ready pattern.
- Upstream protocol violations (in_valid with in_ready=0): the word is ignored and state is unchanged.

Test Plan:
- Configuration for all scenarios: WIDTH=8, DEPTH_LOG2=3, ALMOST_FULL=6.
- Reset, then idle 5 cycles -> count=0, out_valid=0, in_ready=1, almost_full=0 every cycle.
- Push 0xA5 at edge 0 with out_ready=0 -> out_valid=0 after edge 1; out_valid=1 and out_data=0xA5 from edge 2; count=1 from edge 0.
- Push 0x00..0x09 continuously with out_ready=0:
  - pushes 0x00..0x07 are accepted;
  - almost_full=1 after the 6th push, in_ready=0 after the 8th, count=8;
  - 0x08 and 0x09 are rejected.
  - Then hold out_ready=1 -> pops 0x00..0x07 in order, one per cycle with no gaps, ending with count=0 and out_valid=0.
- Random in_valid/out_ready at 50%/50% for 2000 cycles with incrementing data:
  - scoreboard shows strict order with no loss;
  - count always equals pushes minus pops;
  - count never exceeds 8;
  - pointer wrap exercised at least 100 times.
- Fill with 5 entries, assert reset for 1 cycle while in_valid=1 and out_ready=1 -> after the reset edge count=0, out_valid=0; pre-reset data never reappears on subsequent pushes and pops.
- Steady state with count=1, push and pop on the same edge for 20 cycles -> count stays 1; every pushed word emerges in order; out_valid is low for no more than 1 consecutive cycle.
